// File: rtl/hash_nonce_search.sv
// Nonce search driver for the hash core: packs header + nonce, pulses ready,
// qualifies the digest against the target and steps the nonce until done.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; outputs hold the last search result
// S_LOAD  | core input bytes loaded with header and current nonce
// S_REQ   | ready raised, wait counter cleared
// S_WAIT  | ready held, waiting for hash_valid or timeout
// S_CHECK | ready dropped, digest compared against target
// S_DONE  | one-cycle done pulse, search finished
module hash_nonce_search #(
    parameter logic [31:0] MAX_NONCE = 32'h0000_FFFF,
    parameter int          WAIT_MAX  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [95:0] block_in,
    input  logic [7:0]  target,
    input  logic        hash_valid,
    input  logic [7:0]  hash_array0,
    input  logic [7:0]  hash_array1,
    input  logic [7:0]  hash_array2,
    output logic [7:0]  array_numbers0,
    output logic [7:0]  array_numbers1,
    output logic [7:0]  array_numbers2,
    output logic [7:0]  array_numbers3,
    output logic [7:0]  array_numbers4,
    output logic [7:0]  array_numbers5,
    output logic [7:0]  array_numbers6,
    output logic [7:0]  array_numbers7,
    output logic [7:0]  array_numbers8,
    output logic [7:0]  array_numbers9,
    output logic [7:0]  array_numbers10,
    output logic [7:0]  array_numbers11,
    output logic [7:0]  array_numbers12,
    output logic [7:0]  array_numbers13,
    output logic [7:0]  array_numbers14,
    output logic [7:0]  array_numbers15,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic        timeout,
    output logic [31:0] nonce_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_REQ, S_WAIT, S_CHECK, S_DONE
    } state_t;

    localparam int                CNT_W     = $clog2(WAIT_MAX);
    // REQ plus the WAIT cycles seen so far make up the ready-high time
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(WAIT_MAX - 2);

    state_t             state_q, state_d;
    logic [95:0]        hdr_q, hdr_d;
    logic [7:0]         target_q, target_d;
    logic [31:0]        nonce_q, nonce_d;
    logic [31:0]        nonce_out_q, nonce_out_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [127:0]       pack_q, pack_d;
    logic               found_q, found_d;
    logic               timeout_q, timeout_d;
    logic               hash_pass;
    logic               unused_hash2;

    assign unused_hash2 = ^hash_array2;
    assign hash_pass    = (hash_array0 < target_q) && (hash_array1 < target_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            hdr_q       <= '0;
            target_q    <= '0;
            nonce_q     <= '0;
            nonce_out_q <= '0;
            wait_cnt_q  <= '0;
            pack_q      <= '0;
            found_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            target_q    <= target_d;
            nonce_q     <= nonce_d;
            nonce_out_q <= nonce_out_d;
            wait_cnt_q  <= wait_cnt_d;
            pack_q      <= pack_d;
            found_q     <= found_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        target_d    = target_q;
        nonce_d     = nonce_q;
        nonce_out_d = nonce_out_q;
        wait_cnt_d  = wait_cnt_q;
        pack_d      = pack_q;
        found_d     = found_q;
        timeout_d   = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    hdr_d     = block_in;
                    target_d  = target;
                    nonce_d   = '0;
                    found_d   = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                pack_d  = {hdr_q, nonce_q};
                state_d = S_REQ;
            end
            S_REQ: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (hash_valid) begin
                    state_d = S_CHECK;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_d   = 1'b1;
                    nonce_out_d = nonce_q;
                    state_d     = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (hash_pass) begin
                    found_d     = 1'b1;
                    nonce_out_d = nonce_q;
                    state_d     = S_DONE;
                end else if (nonce_q == MAX_NONCE) begin
                    nonce_out_d = nonce_q;
                    state_d     = S_DONE;
                end else begin
                    nonce_d = nonce_q + 32'd1;
                    state_d = S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign ready     = (state_q == S_REQ) || (state_q == S_WAIT);
    assign busy      = (state_q == S_LOAD) || (state_q == S_REQ) ||
                       (state_q == S_WAIT) || (state_q == S_CHECK);
    assign done      = (state_q == S_DONE);
    assign found     = found_q;
    assign timeout   = timeout_q;
    assign nonce_out = nonce_out_q;

    assign array_numbers0  = pack_q[127:120];
    assign array_numbers1  = pack_q[119:112];
    assign array_numbers2  = pack_q[111:104];
    assign array_numbers3  = pack_q[103:96];
    assign array_numbers4  = pack_q[95:88];
    assign array_numbers5  = pack_q[87:80];
    assign array_numbers6  = pack_q[79:72];
    assign array_numbers7  = pack_q[71:64];
    assign array_numbers8  = pack_q[63:56];
    assign array_numbers9  = pack_q[55:48];
    assign array_numbers10 = pack_q[47:40];
    assign array_numbers11 = pack_q[39:32];
    assign array_numbers12 = pack_q[31:24];
    assign array_numbers13 = pack_q[23:16];
    assign array_numbers14 = pack_q[15:8];
    assign array_numbers15 = pack_q[7:0];

endmodule

// File: tb/tb_hash_nonce_search.sv
// Bench for hash_nonce_search: two instances (full range and MAX_NONCE=7),
// each with a latency-4 hash model and a done-driven scoreboard.
module tb_hash_nonce_search;

    typedef struct {
        logic        found;
        logic        tmo;
        logic [31:0] nonce;
        logic [7:0]  a0;
        logic [7:0]  a11;
        logic [7:0]  a15;
    } exp_t;

    localparam logic [95:0] HDR = 96'h0102030405060708090A0B0C;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [95:0] block_in = '0;
    logic [7:0]  target = '0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    logic        a_start = 1'b0, a_hv, a_ready, a_busy, a_done, a_found, a_tmo;
    logic [7:0]  a_h0, a_h1, a_h2;
    logic [7:0]  a_an [16];
    logic [127:0] a_flat;
    logic [31:0] a_nonce;
    logic [3:0]  a_cnt = '0;
    logic        a_never = 1'b0;

    logic        b_start = 1'b0, b_hv, b_ready, b_busy, b_done, b_found, b_tmo;
    logic [7:0]  b_h0, b_h1, b_h2;
    logic [7:0]  b_an [16];
    logic [127:0] b_flat;
    logic [31:0] b_nonce;
    logic [3:0]  b_cnt = '0;
    logic        b_ready_prev = 1'b0;
    int          b_pulses = 0;

    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hash_nonce_search u_dut_a (
        .clk(clk), .reset(reset), .start(a_start), .block_in(block_in), .target(target),
        .hash_valid(a_hv), .hash_array0(a_h0), .hash_array1(a_h1), .hash_array2(a_h2),
        .array_numbers0(a_an[0]), .array_numbers1(a_an[1]), .array_numbers2(a_an[2]),
        .array_numbers3(a_an[3]), .array_numbers4(a_an[4]), .array_numbers5(a_an[5]),
        .array_numbers6(a_an[6]), .array_numbers7(a_an[7]), .array_numbers8(a_an[8]),
        .array_numbers9(a_an[9]), .array_numbers10(a_an[10]), .array_numbers11(a_an[11]),
        .array_numbers12(a_an[12]), .array_numbers13(a_an[13]), .array_numbers14(a_an[14]),
        .array_numbers15(a_an[15]), .ready(a_ready), .busy(a_busy), .done(a_done),
        .found(a_found), .timeout(a_tmo), .nonce_out(a_nonce)
    );

    hash_nonce_search #(.MAX_NONCE(32'h0000_0007), .WAIT_MAX(64)) u_dut_b (
        .clk(clk), .reset(reset), .start(b_start), .block_in(block_in), .target(target),
        .hash_valid(b_hv), .hash_array0(b_h0), .hash_array1(b_h1), .hash_array2(b_h2),
        .array_numbers0(b_an[0]), .array_numbers1(b_an[1]), .array_numbers2(b_an[2]),
        .array_numbers3(b_an[3]), .array_numbers4(b_an[4]), .array_numbers5(b_an[5]),
        .array_numbers6(b_an[6]), .array_numbers7(b_an[7]), .array_numbers8(b_an[8]),
        .array_numbers9(b_an[9]), .array_numbers10(b_an[10]), .array_numbers11(b_an[11]),
        .array_numbers12(b_an[12]), .array_numbers13(b_an[13]), .array_numbers14(b_an[14]),
        .array_numbers15(b_an[15]), .ready(b_ready), .busy(b_busy), .done(b_done),
        .found(b_found), .timeout(b_tmo), .nonce_out(b_nonce)
    );

    // Hash models: digest valid once ready has been high for 4 cycles
    always @(posedge clk) begin
        if (!a_ready) a_cnt <= '0;
        else if (a_cnt != 4'hF) a_cnt <= a_cnt + 4'd1;
        if (!b_ready) b_cnt <= '0;
        else if (b_cnt != 4'hF) b_cnt <= b_cnt + 4'd1;
        b_ready_prev <= b_ready;
        if (b_ready && !b_ready_prev) b_pulses <= b_pulses + 1;
    end

    assign a_hv = a_ready && !a_never && (a_cnt >= 4'd4);
    assign a_h0 = 8'hFF - a_an[15];
    assign a_h1 = 8'h00;
    assign a_h2 = 8'h5A;
    assign b_hv = b_ready && (b_cnt >= 4'd4);
    assign b_h0 = 8'hFF - b_an[15];
    assign b_h1 = 8'h00;
    assign b_h2 = 8'hA5;

    always_comb begin
        a_flat = '0;
        b_flat = '0;
        for (int i = 0; i < 16; i++) begin
            a_flat[127-8*i -: 8] = a_an[i];
            b_flat[127-8*i -: 8] = b_an[i];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_result(input string p, input exp_t e, input logic fnd, input logic tmo,
                              input logic [31:0] n, input logic [127:0] fl);
        chk({p, "_found"}, 32'(fnd), 32'(e.found));
        chk({p, "_timeout"}, 32'(tmo), 32'(e.tmo));
        chk({p, "_nonce_out"}, n, e.nonce);
        chk({p, "_arr0"}, 32'(fl[127:120]), 32'(e.a0));
        chk({p, "_arr11"}, 32'(fl[39:32]), 32'(e.a11));
        chk({p, "_arr15"}, 32'(fl[7:0]), 32'(e.a15));
    endtask

    task automatic chk_zero(input string p, input logic bsy, input logic rdy, input logic dn,
                            input logic fnd, input logic tmo, input logic [31:0] n,
                            input logic [127:0] fl);
        chk({p, "_busy"}, 32'(bsy), 32'd0);
        chk({p, "_ready"}, 32'(rdy), 32'd0);
        chk({p, "_done"}, 32'(dn), 32'd0);
        chk({p, "_found"}, 32'(fnd), 32'd0);
        chk({p, "_timeout"}, 32'(tmo), 32'd0);
        chk({p, "_nonce_out"}, n, 32'd0);
        chk({p, "_arr_w0"}, fl[127:96], 32'd0);
        chk({p, "_arr_w1"}, fl[95:64], 32'd0);
        chk({p, "_arr_w2"}, fl[63:32], 32'd0);
        chk({p, "_arr_w3"}, fl[31:0], 32'd0);
    endtask

    // Scoreboard monitors: every done pulse consumes one expected result
    always @(negedge clk) begin
        if (reset && a_done) begin
            if (qa.size() == 0) chk("a_unexpected_done", 32'd1, 32'd0);
            else chk_result("a", qa.pop_front(), a_found, a_tmo, a_nonce, a_flat);
        end
        if (reset && b_done) begin
            if (qb.size() == 0) chk("b_unexpected_done", 32'd1, 32'd0);
            else chk_result("b", qb.pop_front(), b_found, b_tmo, b_nonce, b_flat);
        end
    end

    task automatic pulse_a();
        @(negedge clk); a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
    endtask

    task automatic wait_done_a(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (a_done) seen = 1;
        end
        if (!seen) chk("a_done_wait_expired", 32'd1, 32'd0);
    endtask

    initial begin
        exp_t e;
        int   p0, t0, t1;
        bit   seen_r, seen_t, seen_d;

        repeat (3) @(negedge clk);
        chk_zero("rst_a", a_busy, a_ready, a_done, a_found, a_tmo, a_nonce, a_flat);
        chk_zero("rst_b", b_busy, b_ready, b_done, b_found, b_tmo, b_nonce, b_flat);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Search finds nonce 0xF0 on the full-range instance
        block_in = HDR; target = 8'h10;
        e = '{1'b1, 1'b0, 32'h0000_00F0, 8'h01, 8'h0C, 8'hF0};
        qa.push_back(e);
        pulse_a();
        wait_done_a(3000);
        repeat (3) @(negedge clk);

        // Unreachable target: exhaustion at MAX_NONCE=7 after 8 attempts
        target = 8'h00;
        e = '{1'b0, 1'b0, 32'h0000_0007, 8'h01, 8'h0C, 8'h07};
        qb.push_back(e);
        p0 = b_pulses;
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        seen_d = 0;
        for (int i = 0; i < 200 && !seen_d; i++) begin
            @(negedge clk);
            if (b_done) seen_d = 1;
        end
        if (!seen_d) chk("b_done_wait_expired", 32'd1, 32'd0);
        chk("b_ready_pulses", 32'(b_pulses - p0), 32'd8);
        repeat (3) @(negedge clk);

        // Hash core never responds: timeout 64 cycles after ready rises
        a_never = 1'b1; target = 8'h10;
        e = '{1'b0, 1'b1, 32'h0000_0000, 8'h01, 8'h0C, 8'h00};
        qa.push_back(e);
        pulse_a();
        seen_r = 0; seen_t = 0; seen_d = 0; t0 = 0; t1 = 0;
        for (int i = 0; i < 200 && !seen_d; i++) begin
            if (a_ready && !seen_r) begin seen_r = 1; t0 = cyc; end
            if (a_tmo && !seen_t) begin seen_t = 1; t1 = cyc; end
            if (a_done) seen_d = 1;
            if (!seen_d) @(negedge clk);
        end
        if (!seen_d || !seen_r || !seen_t) chk("a_timeout_wait_expired", 32'd1, 32'd0);
        chk("a_timeout_latency", 32'(t1 - t0), 32'd64);
        a_never = 1'b0;
        repeat (3) @(negedge clk);

        // Restart while busy and header/target changes are ignored
        block_in = HDR; target = 8'h10;
        e = '{1'b1, 1'b0, 32'h0000_00F0, 8'h01, 8'h0C, 8'hF0};
        qa.push_back(e);
        pulse_a();
        repeat (30) @(negedge clk);
        block_in = {12{8'hEE}}; target = 8'hFF;
        pulse_a();
        wait_done_a(3000);
        repeat (3) @(negedge clk);

        // Reset in WAIT of nonce 5, then a fresh search from nonce 0
        block_in = HDR; target = 8'h10;
        pulse_a();
        seen_r = 0;
        for (int i = 0; i < 100 && !seen_r; i++) begin
            @(negedge clk);
            if (a_ready && a_an[15] == 8'h05) seen_r = 1;
        end
        if (!seen_r) chk("a_nonce5_wait_expired", 32'd1, 32'd0);
        repeat (2) @(negedge clk);
        chk("a_in_wait_before_reset", 32'(a_ready && a_busy), 32'd1);
        reset = 1'b0;
        #1;
        chk_zero("midrst_a", a_busy, a_ready, a_done, a_found, a_tmo, a_nonce, a_flat);
        @(negedge clk);
        reset = 1'b1;
        e = '{1'b1, 1'b0, 32'h0000_00F0, 8'h01, 8'h0C, 8'hF0};
        qa.push_back(e);
        pulse_a();
        seen_r = 0;
        for (int i = 0; i < 20 && !seen_r; i++) begin
            @(negedge clk);
            if (a_ready) seen_r = 1;
        end
        if (!seen_r) chk("a_restart_ready_expired", 32'd1, 32'd0);
        chk("a_restart_nonce0", 32'(a_an[15]), 32'd0);
        chk("a_restart_arr0", 32'(a_an[0]), 32'h01);
        wait_done_a(3000);
        repeat (5) @(negedge clk);

        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hash_nonce_search.md
Name: hash_nonce_search

Overview:
- Upstream driver for the hash core. It accepts a 12-byte block header and an 8-bit target.
- It packs the header plus a 32-bit nonce into the 16 input bytes of the hash core and pulses the core's ready.
- It waits for the digest, checks it against the target, and increments the nonce until a valid hash is found, the nonce range is exhausted, or the core times out.
- Sits between the block-source logic and the hash core.

Parameters:
MAX_NONCE  32'h0000_FFFF  last nonce tried before exhaustion
WAIT_MAX   64  max cycles to wait for hash_valid before timeout error

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to begin a search; ignored unless idle
block_in  input  96  header bytes; block_in[95:88] -> array_numbers0 ... block_in[7:0] -> array_numbers11
target  input  8  difficulty threshold
hash_valid  input  1  hash core digest valid (level, held while digest stable)
hash_array0, hash_array1, hash_array2  input  8 each  digest bytes from hash core
array_numbers0 .. array_numbers15  output  8 each  hash core input bytes
ready  output  1  drives hash core ready/enable
busy  output  1  search in progress
done  output  1  one-cycle pulse at end of search
found  output  1  sticky: last search found a valid nonce
timeout  output  1  sticky: last search aborted on hash core timeout
nonce_out  output  32  winning nonce (or last tried nonce on failure)

Behaviour:
- Reset (reset=0, async): all outputs 0, array_numbers* = 0, state IDLE, nonce = 0, wait counter = 0.
- Header and target are latched on the cycle start is accepted; later changes on block_in/target have no effect during the search.
- Byte packing: array_numbers0..11 come from the latched header. array_numbers12..15 carry the nonce, MSB first: nonce[31:24] .. nonce[7:0].
- IDLE:
  - On start=1: latch inputs, nonce=0, clear found/timeout, busy=1, go LOAD.
- LOAD (1 cycle):
  - Drive array_numbers with the current nonce. ready=0. Go REQ.
- REQ:
  - ready=1, wait counter cleared. Go WAIT next cycle.
  - ready stays 1 through WAIT.
- WAIT:
  - ready=1; wait counter increments each cycle.
  - If hash_valid=1: go CHECK.
  - Else if the counter reaches WAIT_MAX: timeout=1, go DONE.
- CHECK (1 cycle, ready=0):
  - Valid hash ⇔ hash_array0 < target AND hash_array1 < target. The comparison is unsigned; hash_array2 is ignored.
  - Valid: found=1, nonce_out=nonce, go DONE.
  - Invalid and nonce==MAX_NONCE: nonce_out=nonce, go DONE (found=0).
  - Otherwise: nonce+1, go LOAD.
- DONE (1 cycle):
  - done=1, busy=0, ready=0. Go IDLE.
- Per-attempt timing:
  - ready is low for at least 2 cycles (CHECK, LOAD) between attempts, so the hash core restarts.
  - Attempt latency = 3 + hash core latency cycles.
- array_numbers hold their value from LOAD through CHECK. They are not cleared in IDLE; they keep the last value.
- start while busy: ignored, with no effect on the nonce or state.
- start in the DONE cycle: ignored. start is accepted only in IDLE.
- target=0: no hash can pass. The search runs to MAX_NONCE and finishes with found=0.
- Nonce arithmetic is 32-bit. The search never wraps, because termination at MAX_NONCE comes first.
- Reset asserted mid-search: immediate return to the reset state. done is not pulsed.

Test Plan:
All scenarios use a bench hash model with latency 4 and hash_array0 = 8'hFF - nonce[7:0], hash_array1 = 0.
- Reset then idle: all outputs 0 → busy=0, ready=0, array_numbers*=0.
- block_in=96'h0102030405060708090A0B0C, target=8'h10, start → found=1 with nonce_out=32'h0000_00F0. Also check array_numbers0=8'h01, array_numbers11=8'h0C, array_numbers15=8'hF0 at the final attempt, and exactly one done pulse.
- target=8'h00, MAX_NONCE=32'h0000_0007 → 8 attempts, ready pulses counted = 8, found=0, nonce_out=7, done pulse.
- Model never asserts hash_valid, WAIT_MAX=64 → timeout=1 exactly 64 cycles after the first ready rise. found=0 and nonce_out=0.
- Second start pulse during a search, and block_in changed mid-search → ignored; result identical to the second scenario (nonce_out=32'h0000_00F0).
- reset=0 pulsed while in WAIT of nonce 5 → outputs immediately 0, state IDLE. A new start restarts at nonce 0.
